// File: rtl/eq_pkg.sv
// eq_pkg: shared constants, types and helpers for the EQ gain ramp block.
//   NBANDS/GW   - band count and per-band gain width (4 x 8 bits = one EQ word)
//   UNITY       - reset gain (0 dB)
//   MAX_GAIN    - ceiling applied to every captured target
//   ramp_state_t- controller states
package eq_pkg;

    localparam int unsigned NBANDS = 4;
    localparam int unsigned GW     = 8;

    localparam logic [GW-1:0] UNITY    = 8'h80;
    localparam logic [GW-1:0] MAX_GAIN = 8'hF0;

    typedef logic [GW-1:0]           gain_t;
    typedef gain_t [NBANDS-1:0]      gains_t;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        RAMP
    } ramp_state_t;

    function automatic gain_t clamp_gain(input gain_t g);
        return (g > MAX_GAIN) ? MAX_GAIN : g;
    endfunction

endpackage

// File: rtl/eq_gain_ramp_if.sv
// eq_gain_ramp_if: groups the EQ word input, tick and gain/status outputs.
//   master - producer side (drives done, eq_vals, sample_tick; observes status)
//   slave  - the gain ramp block itself
//   done        : eq_spi transfer-done level (sck domain)
//   eq_vals     : packed four-band EQ word, stable while done is high
//   sample_tick : one-clk pulse per audio sample
//   gain/target : live and latched gains, band b at [GW*b +: GW]
//   busy        : some band still ramping
//   clamped     : sticky, a captured band exceeded MAX_GAIN
//   upd_cnt     : number of captured words (wraps)
interface eq_gain_ramp_if;
    import eq_pkg::*;

    logic        done;
    logic [31:0] eq_vals;
    logic        sample_tick;
    gains_t      gain;
    gains_t      target;
    logic        busy;
    logic        clamped;
    logic [7:0]  upd_cnt;

    modport master (
        output done, eq_vals, sample_tick,
        input  gain, target, busy, clamped, upd_cnt
    );

    modport slave (
        input  done, eq_vals, sample_tick,
        output gain, target, busy, clamped, upd_cnt
    );

endinterface

// File: rtl/sync_rise.sv
// sync_rise: two-flop synchroniser for an asynchronous level, followed by a
// rising-edge pulse generator.
//   clk, reset : clock and synchronous active-high reset
//   d          : asynchronous level input
//   rise       : one-cycle pulse when the synchronised level goes high after
//                having been low for at least two cycles
module sync_rise (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    // [0],[1] synchroniser stages; [2],[3] history of the synchronised level
    logic [3:0] sync_q;
    logic [3:0] sync_d;

    always_comb begin
        sync_d = {sync_q[2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Requiring two low history samples rejects a single-cycle dropout of done.
    assign rise = sync_q[1] & ~sync_q[2] & ~sync_q[3];

endmodule

// File: rtl/eq_gain_ramp.sv
// eq_gain_ramp: captures the EQ word when eq_spi signals done, clamps the four
// band targets and slews each live gain toward its target by STEP every
// RAMP_DIV sample ticks to avoid zipper noise.
//   clk, reset : clock and synchronous active-high reset
//   bus        : eq_gain_ramp_if slave (done/eq_vals/sample_tick in,
//                gain/target/busy/clamped/upd_cnt out)
module eq_gain_ramp
    import eq_pkg::*;
#(
    parameter int unsigned RAMP_DIV = 48,
    parameter int unsigned STEP     = 1
) (
    input  logic          clk,
    input  logic          reset,
    eq_gain_ramp_if.slave bus
);

    localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic [GW:0]   STEP_W     = (GW + 1)'(STEP);

    ramp_state_t state_q, state_d;
    gains_t      gain_q, gain_d;
    gains_t      target_q, target_d;
    logic        busy_q, busy_d;
    logic        clamped_q, clamped_d;
    logic [7:0]  upd_cnt_q, upd_cnt_d;
    logic [PW-1:0] presc_q, presc_d;

    logic done_rise;

    sync_rise u_sync_rise (
        .clk   (clk),
        .reset (reset),
        .d     (bus.done),
        .rise  (done_rise)
    );

    gains_t              word_bands;
    gains_t              cap_target;
    gains_t              stepped;
    logic [NBANDS-1:0]   over;
    logic [NBANDS-1:0]   cap_diff;
    logic [NBANDS-1:0]   step_diff;

    assign word_bands = bus.eq_vals;

    for (genvar b = 0; b < NBANDS; b++) begin : g_band
        logic [GW:0] up_diff, dn_diff, up_amt, dn_amt;

        // GW+1-bit differences keep the step size free of wrap-around.
        assign up_diff = {1'b0, target_q[b]} - {1'b0, gain_q[b]};
        assign dn_diff = {1'b0, gain_q[b]} - {1'b0, target_q[b]};
        assign up_amt  = (up_diff < STEP_W) ? up_diff : STEP_W;
        assign dn_amt  = (dn_diff < STEP_W) ? dn_diff : STEP_W;

        assign stepped[b] = (target_q[b] > gain_q[b]) ? gain_q[b] + up_amt[GW-1:0] :
                            (target_q[b] < gain_q[b]) ? gain_q[b] - dn_amt[GW-1:0] :
                                                        gain_q[b];

        assign cap_target[b] = clamp_gain(word_bands[b]);
        assign over[b]       = word_bands[b] > MAX_GAIN;
        assign cap_diff[b]   = gain_q[b] != cap_target[b];
        assign step_diff[b]  = stepped[b] != target_q[b];
    end

    always_comb begin
        state_d   = state_q;
        gain_d    = gain_q;
        target_d  = target_q;
        busy_d    = busy_q;
        clamped_d = clamped_q;
        upd_cnt_d = upd_cnt_q;
        presc_d   = presc_q;

        unique case (state_q)
            IDLE: begin
                presc_d = '0;
                if (done_rise) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                target_d  = cap_target;
                upd_cnt_d = upd_cnt_q + 8'd1;
                if (|over) begin
                    clamped_d = 1'b1;
                end
                busy_d  = |cap_diff;
                state_d = (|cap_diff) ? RAMP : IDLE;
            end
            RAMP: begin
                if (bus.sample_tick) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        gain_d  = stepped;
                        if (!(|step_diff)) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                // A new word retargets mid-ramp; the prescaler keeps its phase.
                if (done_rise) begin
                    state_d = CAPTURE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gain_q    <= {NBANDS{UNITY}};
            target_q  <= {NBANDS{UNITY}};
            busy_q    <= 1'b0;
            clamped_q <= 1'b0;
            upd_cnt_q <= 8'd0;
            presc_q   <= '0;
        end else begin
            state_q   <= state_d;
            gain_q    <= gain_d;
            target_q  <= target_d;
            busy_q    <= busy_d;
            clamped_q <= clamped_d;
            upd_cnt_q <= upd_cnt_d;
            presc_q   <= presc_d;
        end
    end

    assign bus.gain    = gain_q;
    assign bus.target  = target_q;
    assign bus.busy    = busy_q;
    assign bus.clamped = clamped_q;
    assign bus.upd_cnt = upd_cnt_q;

endmodule

// File: tb/tb_eq_gain_ramp.sv
// tb_eq_gain_ramp: directed and random stimulus for eq_gain_ramp. A reference
// model tracks per-band gains/targets as plain arithmetic; expected gain steps
// and captures are queued and popped by a monitor when the DUT output changes.
module tb_eq_gain_ramp;

    localparam int unsigned RDIV = 2;

    logic clk;
    logic reset;

    eq_gain_ramp_if bus ();

    eq_gain_ramp #(
        .RAMP_DIV (RDIV),
        .STEP     (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  upd;
        logic [31:0] tgt;
        logic        clamped;
    } cap_t;

    logic [31:0] gain_exp[$];
    cap_t        cap_exp[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_gain[4];
    int          m_tgt[4];
    int          m_presc;
    logic [7:0]  m_upd;
    logic        m_clamped;

    bit          mon_en = 1'b0;
    logic [31:0] prev_gain;
    logic [7:0]  prev_upd;

    function automatic logic [31:0] pack4(input int v0, input int v1, input int v2, input int v3);
        logic [31:0] r;
        r = {v3[7:0], v2[7:0], v1[7:0], v0[7:0]};
        return r;
    endfunction

    function automatic logic [31:0] m_gain_word();
        return pack4(m_gain[0], m_gain[1], m_gain[2], m_gain[3]);
    endfunction

    function automatic logic [31:0] m_tgt_word();
        return pack4(m_tgt[0], m_tgt[1], m_tgt[2], m_tgt[3]);
    endfunction

    function automatic bit m_busy();
        for (int b = 0; b < 4; b++) if (m_gain[b] != m_tgt[b]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < 4; b++) begin
            m_gain[b] = 'h80;
            m_tgt[b]  = 'h80;
        end
        m_presc   = 0;
        m_upd     = 8'd0;
        m_clamped = 1'b0;
    endfunction

    function automatic void model_capture(input logic [31:0] w);
        cap_t c;
        for (int b = 0; b < 4; b++) begin
            int v;
            v = int'(w[8*b +: 8]);
            if (v > 'hF0) begin
                v = 'hF0;
                m_clamped = 1'b1;
            end
            m_tgt[b] = v;
        end
        m_upd = m_upd + 8'd1;
        if (!m_busy()) m_presc = 0;
        c.upd     = m_upd;
        c.tgt     = m_tgt_word();
        c.clamped = m_clamped;
        cap_exp.push_back(c);
    endfunction

    // One sample tick: counts toward a step only while some band is off target.
    function automatic void model_tick();
        if (!m_busy()) begin
            m_presc = 0;
            return;
        end
        m_presc++;
        if (m_presc == RDIV) begin
            m_presc = 0;
            for (int b = 0; b < 4; b++) begin
                if (m_gain[b] < m_tgt[b]) m_gain[b]++;
                else if (m_gain[b] > m_tgt[b]) m_gain[b]--;
            end
            gain_exp.push_back(m_gain_word());
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output monitor: every observed change must match the next queued value.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.gain !== prev_gain) begin
                checks++;
                if (gain_exp.size() == 0) begin
                    errors++;
                    $display("FAIL gain_step: got %h expected no change from %h",
                             bus.gain, prev_gain);
                end else begin
                    logic [31:0] e;
                    e = gain_exp.pop_front();
                    if (bus.gain !== e) begin
                        errors++;
                        $display("FAIL gain_step: got %h expected %h", bus.gain, e);
                    end
                end
                prev_gain = bus.gain;
            end
            if (bus.upd_cnt !== prev_upd) begin
                checks++;
                if (cap_exp.size() == 0) begin
                    errors++;
                    $display("FAIL capture: got upd_cnt %h expected no capture", bus.upd_cnt);
                end else begin
                    cap_t c;
                    c = cap_exp.pop_front();
                    if (bus.upd_cnt !== c.upd || bus.target !== c.tgt ||
                        bus.clamped !== c.clamped) begin
                        errors++;
                        $display("FAIL capture: got upd=%h tgt=%h clamped=%b expected upd=%h tgt=%h clamped=%b",
                                 bus.upd_cnt, bus.target, bus.clamped, c.upd, c.tgt, c.clamped);
                    end
                end
                prev_upd = bus.upd_cnt;
            end
        end
    end

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.sample_tick = 1'b1;
            model_tick();
            @(posedge clk);
            #1;
            bus.sample_tick = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] w, input int hold);
        @(posedge clk);
        #1;
        bus.eq_vals = w;
        bus.done    = 1'b1;
        model_capture(w);
        repeat (hold) @(posedge clk);
        #1;
        bus.done = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        if (m_gain_word() != 32'h80808080) gain_exp.push_back(32'h80808080);
        if (m_upd != 8'd0) begin
            cap_t c;
            c.upd     = 8'd0;
            c.tgt     = 32'h80808080;
            c.clamped = 1'b0;
            cap_exp.push_back(c);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset           = 1'b1;
        bus.done        = 1'b0;
        bus.eq_vals     = 32'h0;
        bus.sample_tick = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        prev_gain = 32'h80808080;
        prev_upd  = 8'd0;
        mon_en    = 1'b1;
        @(negedge clk);

        // Reset / idle
        chk("reset_gain", bus.gain, 32'h80808080);
        chk("reset_target", bus.target, 32'h80808080);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_clamped", {31'd0, bus.clamped}, 32'd0);
        chk("reset_upd", {24'd0, bus.upd_cnt}, 32'd0);
        ticks(200);
        @(negedge clk);
        chk("idle_ticks_gain", bus.gain, 32'h80808080);

        // Up/down ramp
        send(32'h80808084, 4);
        chk("up_target", bus.target, 32'h80808084);
        chk("up_upd", {24'd0, bus.upd_cnt}, 32'd1);
        chk("up_busy", {31'd0, bus.busy}, 32'd1);
        ticks(2);
        @(negedge clk);
        chk("up_first_step", bus.gain, 32'h80808081);
        ticks(6);
        @(negedge clk);
        chk("up_final", bus.gain, 32'h80808084);
        chk("up_busy_low", {31'd0, bus.busy}, 32'd0);
        send(32'h7F808084, 4);
        ticks(2);
        @(negedge clk);
        chk("down_final", bus.gain, 32'h7F808084);
        chk("down_busy_low", {31'd0, bus.busy}, 32'd0);

        // Clamp
        send(32'hFF10F180, 4);
        chk("clamp_target", bus.target, 32'hF010F080);
        chk("clamp_flag", {31'd0, bus.clamped}, 32'd1);
        ticks(240);
        @(negedge clk);
        chk("clamp_gain", bus.gain, 32'hF010F080);
        send(32'h80808080, 4);
        ticks(240);
        @(negedge clk);
        chk("clamp_sticky", {31'd0, bus.clamped}, 32'd1);
        do_reset();
        chk("clamp_reset", {31'd0, bus.clamped}, 32'd0);
        chk("clamp_reset_gain", bus.gain, 32'h80808080);

        // Retarget mid-ramp
        send(32'h90909090, 4);
        ticks(6);
        @(negedge clk);
        chk("retarget_mid", bus.gain, 32'h83838383);
        send(32'h80808080, 4);
        chk("retarget_upd", {24'd0, bus.upd_cnt}, 32'd2);
        ticks(8);
        @(negedge clk);
        chk("retarget_final", bus.gain, 32'h80808080);

        // Held done and single-cycle dropout
        send(32'h80808080, 1000);
        chk("held_upd", {24'd0, bus.upd_cnt}, 32'd3);
        @(posedge clk);
        #1;
        bus.eq_vals = 32'h80808080;
        bus.done    = 1'b1;
        model_capture(32'h80808080);
        repeat (5) @(posedge clk);
        #1;
        bus.done = 1'b0;
        @(posedge clk);
        #1;
        bus.done = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.done = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("glitch_upd", {24'd0, bus.upd_cnt}, 32'd4);

        // upd_cnt wrap
        for (int i = 0; i < 256; i++) begin
            send(32'h80808080, 2);
            if (i == 251) chk("wrap_zero", {24'd0, bus.upd_cnt}, 32'd0);
        end
        chk("wrap_full", {24'd0, bus.upd_cnt}, 32'd4);

        // Random words and tick bursts
        for (int i = 0; i < 25; i++) begin
            send($urandom, 1 + $urandom_range(0, 5));
            ticks($urandom_range(0, 300));
        end
        @(negedge clk);
        chk("rand_gain", bus.gain, m_gain_word());
        chk("rand_target", bus.target, m_tgt_word());
        chk("rand_busy", {31'd0, bus.busy}, {31'd0, m_busy()});
        chk("rand_clamped", {31'd0, bus.clamped}, {31'd0, m_clamped});
        chk("rand_upd", {24'd0, bus.upd_cnt}, {24'd0, m_upd});

        // Reset mid-ramp
        do_reset();
        send(32'h90909090, 4);
        ticks(10);
        @(negedge clk);
        chk("pre_reset_gain", bus.gain, 32'h85858585);
        do_reset();
        chk("mid_reset_gain", bus.gain, 32'h80808080);
        chk("mid_reset_target", bus.target, 32'h80808080);
        chk("mid_reset_busy", {31'd0, bus.busy}, 32'd0);
        ticks(4);
        @(negedge clk);
        chk("post_reset_idle", bus.gain, 32'h80808080);

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("gain_queue_drained", gain_exp.size(), 32'd0);
        chk("cap_queue_drained", cap_exp.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
